// File: rtl/mips_defs.sv
// Shared MIPS definitions: exception codes, reset/handler PCs and the
// instruction-memory address window used by the fetch stage.
package mips_defs;

    // Exception codes reported through the pipeline to CP0
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Program-counter landmarks
    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

    // Legal instruction-fetch window (inclusive, word addresses)
    localparam logic [31:0] IM_LO = 32'h0000_3000;
    localparam logic [31:0] IM_HI = 32'h0000_6FFC;

endpackage

// File: rtl/f_npc_sel.sv
// Next-PC priority mux for the fetch stage. Reset is applied by the PC
// register itself; this block covers everything below it in priority:
// exception entry, stall hold, eret, branch/jump redirect, sequential.
module f_npc_sel
    import mips_defs::*;
#(
    parameter logic [31:0] ENTRY_PC = EXC_ENTRY
) (
    input  logic [31:0] i_pc,
    input  logic        i_req,
    input  logic        i_stall,
    input  logic        i_eret,
    input  logic [31:0] i_epc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_npc
);

    logic [31:0] w_seq_pc;

    // Sequential successor wraps naturally at 2^32; an out-of-window result
    // is caught by the address check on the following fetch.
    assign w_seq_pc = i_pc + 32'd4;

    // First matching source wins; exception entry must beat a stall so a
    // taken interrupt is never delayed by a hazard.
    always_comb begin
        o_npc = w_seq_pc;
        if (i_req) begin
            o_npc = ENTRY_PC;
        end else if (i_stall) begin
            o_npc = i_pc;
        end else if (i_eret) begin
            o_npc = i_epc;
        end else if (i_redirect) begin
            o_npc = i_redirect_pc;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the architectural PC, drives the instruction-memory
// address and builds the {instr, pc, EXcode, delay} bundle for the F/D
// register. Fetch-address errors and the eret wrong-path kill are resolved
// combinationally on the current PC.
module f_fetch_unit #(
    parameter logic [31:0] PC_RESET  = mips_defs::PC_RESET,
    parameter logic [31:0] EXC_ENTRY = mips_defs::EXC_ENTRY,
    parameter logic [31:0] IM_LO     = mips_defs::IM_LO,
    parameter logic [31:0] IM_HI     = mips_defs::IM_HI,
    parameter logic [4:0]  EXC_ADEL  = mips_defs::EXC_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        d_is_bj,
    input  logic [31:0] im_rdata,
    output logic [31:0] im_addr,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic [4:0]  EXcode_out,
    output logic        delay_out
);

    logic [31:0] r_pc;
    logic [31:0] w_npc;
    logic        w_adel;
    logic        w_squash;

    f_npc_sel #(
        .ENTRY_PC (EXC_ENTRY)
    ) u_npc_sel (
        .i_pc          (r_pc),
        .i_req         (req),
        .i_stall       (stall),
        .i_eret        (eret),
        .i_epc         (epc),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_npc         (w_npc)
    );

    // PC register: reset overrides every other next-PC source
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_npc;
        end
    end

    // Misaligned or outside the instruction window
    assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < IM_LO) || (r_pc > IM_HI);

    // eret has no delay slot: the instruction fetched alongside it is on the
    // wrong path and must vanish, including any exception it would raise.
    // Under a stall the eret is still pending, so nothing is killed yet.
    assign w_squash = eret && !stall;

    // The PC is always reported as-is so CP0 captures the right EPC even
    // for a faulting or killed fetch.
    assign pc_out  = r_pc;
    assign im_addr = r_pc;

    // The delay-slot flag never applies to the slot after an eret
    assign delay_out = d_is_bj && !eret;

    // Instruction/exception bundle: killed fetch > address error > memory data
    always_comb begin
        instr_out  = im_rdata;
        EXcode_out = 5'd0;
        if (w_squash) begin
            instr_out  = 32'h0;
            EXcode_out = 5'd0;
        end else if (w_adel) begin
            instr_out  = 32'h0;
            EXcode_out = EXC_ADEL;
        end
    end

endmodule

// File: doc/f_fetch_unit.md
Name: f_fetch_unit

Overview:
- Fetch-stage producer for the F/D pipeline register.
- Owns the architectural fetch PC and drives the instruction-memory address.
- Produces the {instr, pc, EXcode, delay} bundle that the D-stage register latches when its write enable is high.
- Handles reset, stall hold, branch/jump redirect, eret return to EPC, exception-entry redirect and fetch-address exception detection.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, handler entry PC taken on req.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (word-aligned).
- EXC_ADEL, 5'd4, EXcode for a fetch address error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; 1 = hold PC (complement of the D register's WE)
- req  in  1  exception/interrupt taken this cycle (from CP0)
- eret  in  1  eret in D stage, redirect to EPC
- epc  in  32  EPC value from CP0
- redirect  in  1  branch taken or jump resolved in D
- redirect_pc  in  32  branch/jump target from D
- d_is_bj  in  1  D instruction is a branch/jump; current F instr is its delay slot
- im_rdata  in  32  instruction memory read data for im_addr
- im_addr  out  32  instruction memory address (= pc_out)
- pc_out  out  32  F-stage PC to D register
- instr_out  out  32  instruction to D register
- EXcode_out  out  5  fetch exception code to D register (0 = none)
- delay_out  out  1  delay-slot flag to D register

Behaviour:
- State: a single 32-bit PC register. All outputs are derived from the PC plus the current inputs.
- Reset: on a rising clk edge with reset=1, pc <= PC_RESET. After reset:
  - pc_out = im_addr = 0x3000.
  - EXcode_out = 0 (0x3000 is legal).
  - instr_out = im_rdata.
- Next-PC priority, evaluated every rising edge, first match wins:
  1. reset → PC_RESET
  2. req → EXC_ENTRY. Overrides stall.
  3. stall → hold pc.
  4. eret → epc. eret has no delay slot.
  5. redirect → redirect_pc
  6. otherwise → pc + 4, modulo 2^32.
- Simultaneous events:
  - req with eret or redirect → req wins.
  - eret with redirect → eret wins.
  - stall with eret or redirect → hold. D holds the same instruction, so the redirect reasserts next cycle.
- Fetch exception, combinational on the current pc:
  - adel = (pc[1:0] != 0) || (pc < IM_LO) || (pc > IM_HI).
  - When adel=1: EXcode_out = EXC_ADEL and instr_out = 32'h0 (nop). Memory data is never forwarded.
  - When adel=0: EXcode_out = 0 and instr_out = im_rdata.
  - Boundaries: 0x6FFC is legal; 0x7000 and 0x2FFC raise AdEL.
- eret squash: when eret=1 and stall=0, instr_out = 0 and EXcode_out = 0. The wrong-path fetch is killed and reports no exception, even if its pc is illegal.
- delay_out = d_is_bj. It is forced to 0 whenever eret=1.
- pc_out always equals the actual fetch pc, including for a faulting or squashed fetch, so CP0 records the right EPC.
- Latency:
  - A redirect, eret or req visible in cycle N produces the new pc_out in cycle N+1.
  - There is no internal bubble; the D register applies its own flush on req.
- Wrap-around: pc + 4 from 0xFFFF_FFFC gives 0x0000_0000, which raises AdEL. This is not special-cased.
- Reset mid-stall or mid-redirect: reset wins unconditionally.

Decomposition:
- Shared package `mips_defs`:
  - EXcode constants (EXC_ADEL, EXC_INT, EXC_RI, …)
  - PC_RESET and EXC_ENTRY
  - IM_LO / IM_HI address-map constants
- One natural sub-module, `f_npc_sel`: the combinational next-PC priority mux.
- The PC register, AdEL check and output muxing stay in `f_fetch_unit`.

Test Plan:
- Reset, then release: pc_out=0x3000, 0x3004, 0x3008 on successive cycles; EXcode_out=0; instr_out tracks im_rdata.
- redirect=1, redirect_pc=0x3100, d_is_bj=1 at pc=0x3008: delay_out=1 that cycle; next pc_out=0x3100.
- stall=1 for 3 cycles at pc=0x300C, with redirect=1 on the second cycle: pc_out stays 0x300C throughout; pc advances only after stall drops.
- req=1 with stall=1 and redirect=1, redirect_pc=0x3200: next pc_out=0x4180.
- eret=1, epc=0x3010 with redirect=1 to 0x3400: this cycle instr_out=0, delay_out=0; next pc_out=0x3010.
- redirect_pc=0x3002, then a separate run with redirect_pc=0x7000:
  - 0x3002 case: EXcode_out=4, instr_out=0, pc_out=0x3002.
  - 0x7000 case: same, with pc_out=0x7000.
  - Control check: redirect_pc=0x6FFC gives EXcode_out=0.
